ubbcl_add_arbiter: RTL and testbench
====================================

# ubbcl_add_arbiter

Round-robin arbiter and two-stage pipeline wrapper that shares one 19-bit block carry look-ahead adder (UBBCL_18_0_18_0, 20-bit unsigned sum, no carry-in) between N_REQ requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester per cycle, registers the operands in front of the adder, and registers the sum behind it. The result is returned on a single valid/ready output tagged with the requester index. It sits between the requesting datapath units and the shared adder instance.

## Interface
- N_REQ, default 4: number of requesters, 2..16.
- ID_W, default $clog2(N_REQ): width of the requester tag (derived, not overridden).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit set.
- req_x  in  N_REQ*19  operand X; requester i occupies bits [19i+18:19i].
- req_y  in  N_REQ*19  operand Y; same packing as req_x.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accept.
- res_sum  out  20  X+Y, zero-extended; bit 19 is the carry.
- res_id  out  ID_W  index of the requester that issued the operation.
- busy  out  1  high when either pipeline stage holds data.
- op_count  out  16  number of results delivered; wraps modulo 2^16.

## Operation
- Stage A register holds vld_a, x_a, y_a and id_a. The adder reads x_a and y_a combinationally.
- Stage B register holds vld_b, sum_b and id_b, and drives res_valid, res_sum and res_id directly.
- Stage B loads when !vld_b or res_ready. Stage A loads when !vld_a or stage B loads.
- Arbitration:
  - The grant is combinational: the first asserted req_valid at or after rr_ptr, searching in increasing index with modulo wrap.
  - req_ready[g] = grant[g] & (stage A loads).
- Handshake:
  - An accept at an edge is req_valid[i] & req_ready[i]. On accept, stage A captures that requester's operands and id, and rr_ptr becomes (g+1) mod N_REQ.
  - If there is no accept, rr_ptr holds.
  - Requesters hold req_valid, req_x and req_y stable until accepted. req_valid must not depend on req_ready.
- When stage A drains with no accept, vld_a clears. The same applies to stage B on delivery with no new data.
- op_count increments on each res_valid & res_ready edge.
- Arithmetic: the sum is unsigned and exact, 20 bits, so overflow is impossible.
- Reset values:
  - req_ready=0 during rst.
  - res_valid=0, res_sum=0, res_id=0, busy=0, op_count=0, rr_ptr=0, vld_a=0.
  - Reset mid-operation discards both stages without delivering them.

## Timing
- Latency: an accept at edge k gives res_valid=1 after edge k+1 when not stalled (2-cycle register-to-register).
- Throughput: one operation per cycle with res_ready held high.
- Backpressure:
  - With res_ready=0 and both stages full, req_ready is all zero.
  - res_sum and res_id hold stable while res_valid & !res_ready.
- Simultaneous events: stage B delivery and a new load in the same edge is permitted and sustains full throughput. No bubble is inserted.
- Fairness: with all requesters continuously valid and no stall, grants rotate 0,1,…,N_REQ-1,0. Any valid requester waits at most N_REQ-1 accepts.

## Configuration
- ADD_ARB_PRIO0_EN:
  - Defined: requester 0 has absolute priority and is granted whenever req_valid[0]=1. rr_ptr rotates only over requesters 1..N_REQ-1 and is unchanged when requester 0 is accepted.
  - Undefined: pure round-robin over all N_REQ requesters, as described above.

## Structure
- Package add_arb_pkg holds the following:
  - OPW=19 and SUMW=20.
  - Typedef op_t (logic [OPW-1:0]) and typedef sum_t (logic [SUMW-1:0]).
  - Function rr_pick(req, ptr), returning a one-hot grant.
- Sub-module add_rr_arbiter contains the grant logic and rr_ptr register, including the ADD_ARB_PRIO0_EN variant.
- The top level instantiates add_rr_arbiter, the pipeline registers, one UBBCL_18_0_18_0 and op_count.

## Test plan
- Single request, N_REQ=4: requester 2 sends X=0x7FFFF, Y=0x00001 with res_ready=1 -> res_valid two edges after the accept, res_sum=0x80000, res_id=2, op_count=1.
- Carry out: requester 0 sends X=Y=0x7FFFF -> res_sum=0xFFFFE.
- All four requesters valid continuously with res_ready=1 -> res_id sequence 0,1,2,3,0,… with one result per cycle after a 2-cycle fill.
- Hold res_ready=0 for 5 cycles with all requesters valid:
  - Exactly 2 accepts occur, then req_ready=0.
  - res_sum and res_id stay stable.
  - On release, there is no loss or duplication, and op_count matches the number of accepts.
- Assert rst while both stages are full -> next cycle res_valid=0, busy=0, op_count=0, and the first grant goes to requester 0.
- With ADD_ARB_PRIO0_EN defined, requesters 0 and 3 continuously valid -> only id 0 is served. After req_valid[0] drops, requester 3 is granted in the next cycle.

Source files
------------

// File: rtl/add_arb_pkg.sv
// Shared types, widths and the round-robin pick helper for the shared-adder arbiter.
// Latency: none (package only).
// Backpressure: not applicable.
// Contents: OPW/SUMW widths, op_t/sum_t, rr_pick(req, ptr, n) -> one-hot grant.
package add_arb_pkg;

    localparam int OPW  = 19;
    localparam int SUMW = 20;

    typedef logic [OPW-1:0]  op_t;
    typedef logic [SUMW-1:0] sum_t;

    // First asserted request at or after ptr, searching upward with wrap at n.
    // Fixed 16-bit width covers every legal requester count.
    function automatic logic [15:0] rr_pick(input logic [15:0] req,
                                            input logic [3:0]  ptr,
                                            input int          n);
        logic [15:0] g;
        logic        found;
        int          idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && req[idx[3:0]]) begin
                g[idx[3:0]] = 1'b1;
                found       = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/add_rr_arbiter.sv
// Round-robin grant logic and rotation pointer for the shared adder (ADD_ARB_PRIO0_EN: requester 0 absolute priority).
// Latency: grant is combinational from i_req; pointer updates on the accepting edge.
// Backpressure: pointer only advances when i_load is high and a grant exists.
// Ports: i_clk, i_rst (sync, active-high), i_req, i_load -> o_grant (one-hot), o_gid, o_gvld.
module add_rr_arbiter
    import add_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_load,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_gid,
    output logic             o_gvld
);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_ptr_nxt;
    logic [15:0]     w_pick;
    logic [15:0]     w_req16;

    assign w_req16 = 16'(i_req);

`ifdef ADD_ARB_PRIO0_EN
    // Requester 0 wins outright; the others share a rotation that never visits 0.
    always_comb begin
        w_pick = '0;
        if (i_req[0]) begin
            w_pick = 16'd1;
        end else begin
            w_pick = rr_pick(w_req16 & ~16'd1, 4'(r_ptr), N_REQ);
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (o_gid == '0) begin
            w_ptr_nxt = r_ptr;
        end else if (o_gid == ID_W'(N_REQ - 1)) begin
            w_ptr_nxt = ID_W'(1);
        end else begin
            w_ptr_nxt = o_gid + ID_W'(1);
        end
    end
`else
    always_comb begin
        w_pick = rr_pick(w_req16, 4'(r_ptr), N_REQ);
    end

    always_comb begin
        w_ptr_nxt = (o_gid == ID_W'(N_REQ - 1)) ? '0 : o_gid + ID_W'(1);
    end
`endif

    assign o_grant = w_pick[N_REQ-1:0];
    assign o_gvld  = |o_grant;

    always_comb begin
        o_gid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (o_grant[i]) begin
                o_gid = ID_W'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_load && o_gvld) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/ubbcl_18_0_18_0.sv
// 19-bit unsigned carry look-ahead adder, 20-bit sum, no carry-in.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_x, i_y operands; o_sum = i_x + i_y with bit 19 as carry out.
module UBBCL_18_0_18_0 (
    input  logic [18:0] i_x,
    input  logic [18:0] i_y,
    output logic [19:0] o_sum
);

    logic [18:0] w_g;
    logic [18:0] w_p;
    logic [19:0] w_c;

    assign w_g = i_x & i_y;
    assign w_p = i_x ^ i_y;

    // Generate/propagate carry recurrence; synthesis flattens it into look-ahead logic.
    always_comb begin
        w_c    = '0;
        w_c[0] = 1'b0;
        for (int i = 0; i < 19; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    assign o_sum = {w_c[19], w_p ^ w_c[18:0]};

endmodule

// File: rtl/ubbcl_add_arbiter.sv
// Shares one UBBCL_18_0_18_0 adder between N_REQ valid/ready requesters; results tagged with requester id.
// Latency: accept at edge k -> o_res_valid after edge k+1; one op per cycle sustained.
// Backpressure: o_res_ready low holds stage B; stage A then fills and all o_req_ready drop.
// Optional feature macro: ADD_ARB_PRIO0_EN (requester 0 absolute priority).
// Ports: i_clk, i_rst (sync, active-high); i_req_valid/o_req_ready/i_req_x/i_req_y (19 bits per
// requester, packed); o_res_valid/i_res_ready/o_res_sum/o_res_id; o_busy; o_op_count (wraps).
module ubbcl_add_arbiter
    import add_arb_pkg::*;
#(
    parameter int  N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req_valid,
    output logic [N_REQ-1:0]     o_req_ready,
    input  logic [N_REQ*OPW-1:0] i_req_x,
    input  logic [N_REQ*OPW-1:0] i_req_y,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [SUMW-1:0]      o_res_sum,
    output logic [ID_W-1:0]      o_res_id,
    output logic                 o_busy,
    output logic [15:0]          o_op_count
);

    logic             w_load_a;
    logic             w_load_b;
    logic             w_acc;
    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_gid;
    logic             w_gvld;
    op_t              w_x;
    op_t              w_y;
    sum_t             w_sum;

    logic             r_vld_a;
    op_t              r_x_a;
    op_t              r_y_a;
    logic [ID_W-1:0]  r_id_a;
    logic             r_vld_b;
    sum_t             r_sum_b;
    logic [ID_W-1:0]  r_id_b;
    logic [15:0]      r_op_count;

    // Each stage moves whenever the one downstream makes room, so delivery and refill share an edge.
    assign w_load_b = ~r_vld_b | i_res_ready;
    assign w_load_a = ~r_vld_a | w_load_b;
    assign w_acc    = w_gvld & w_load_a & ~i_rst;

    assign o_req_ready = w_grant & {N_REQ{w_load_a & ~i_rst}};

    add_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req_valid),
        .i_load  (w_load_a),
        .o_grant (w_grant),
        .o_gid   (w_gid),
        .o_gvld  (w_gvld)
    );

    assign w_x = i_req_x[w_gid*OPW +: OPW];
    assign w_y = i_req_y[w_gid*OPW +: OPW];

    UBBCL_18_0_18_0 u_add (
        .i_x   (r_x_a),
        .i_y   (r_y_a),
        .o_sum (w_sum)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_a <= 1'b0;
            r_x_a   <= '0;
            r_y_a   <= '0;
            r_id_a  <= '0;
        end else if (w_load_a) begin
            r_vld_a <= w_acc;
            if (w_acc) begin
                r_x_a  <= w_x;
                r_y_a  <= w_y;
                r_id_a <= w_gid;
            end
        end
    end

    // Sum/id only change when a new result enters, keeping them stable while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_b <= 1'b0;
            r_sum_b <= '0;
            r_id_b  <= '0;
        end else if (w_load_b) begin
            r_vld_b <= r_vld_a;
            if (r_vld_a) begin
                r_sum_b <= w_sum;
                r_id_b  <= r_id_a;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op_count <= '0;
        end else if (r_vld_b && i_res_ready) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign o_res_valid = r_vld_b;
    assign o_res_sum   = r_sum_b;
    assign o_res_id    = r_id_b;
    assign o_busy      = r_vld_a | r_vld_b;
    assign o_op_count  = r_op_count;

endmodule

// File: tb/tb_ubbcl_add_arbiter.sv
// Scoreboard bench for ubbcl_add_arbiter: driver offers operands, monitor predicts grants and results.
// Latency: checks the 2-edge accept-to-valid timing on every item.
// Backpressure: exercises res_ready stalls, reset mid-flight and random traffic.
module tb_ubbcl_add_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*19-1:0] req_x;
    logic [N*19-1:0] req_y;
    logic            res_valid;
    logic            res_ready;
    logic [19:0]     res_sum;
    logic [IDW-1:0]  res_id;
    logic            busy;
    logic [15:0]     op_count;

    always #5 clk = ~clk;

    ubbcl_add_arbiter #(.N_REQ(N)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_x     (req_x),
        .i_req_y     (req_y),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_sum   (res_sum),
        .o_res_id    (res_id),
        .o_busy      (busy),
        .o_op_count  (op_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state (owned by monitor) ----------------
    typedef struct {
        int          id;
        logic [19:0] sum;
        int          c;
    } item_t;

    item_t       q[$];
    int          del_ids[$];
    int          m_ptr   = 0;
    int          ncyc    = 0;
    int          m_cnt   = 0;
    int          tot_acc = 0;
    int          win_acc = 0;
    logic [N-1:0] acc_flag = '0;
    logic        held_vld = 1'b0;
    logic [19:0] held_sum;
    logic [IDW-1:0] held_id;
    logic [19:0] last_sum = '0;
    int          last_id  = -1;

    function automatic int exp_grant(input logic [N-1:0] v, input int ptr);
        int idx;
`ifdef ADD_ARB_PRIO0_EN
        int p;
        if (v[0]) return 0;
        p = (ptr == 0) ? 1 : ptr;
        for (int k = 0; k < N - 1; k++) begin
            idx = 1 + ((p - 1 + k) % (N - 1));
            if (v[idx]) return idx;
        end
`else
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (v[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    function automatic int next_ptr(input int g, input int ptr);
`ifdef ADD_ARB_PRIO0_EN
        if (g == 0) return ptr;
        return (g + 1 == N) ? 1 : g + 1;
`else
        return (g + 1) % N;
`endif
    endfunction

    always @(negedge clk) begin
        int          occ;
        int          g;
        logic        can;
        logic [N-1:0] exp_rdy;
        item_t       it;
        if (rst) begin
            chk("ready_in_rst", 32'(req_ready), 32'd0);
            q.delete();
            m_ptr    = 0;
            m_cnt    = 0;
            tot_acc  = 0;
            acc_flag = '0;
            held_vld = 1'b0;
        end else begin
            ncyc++;
            occ = q.size();
            chk("res_valid", 32'(res_valid), 32'((occ > 0) && (ncyc >= q[0].c + 2)));
            chk("busy", 32'(busy), 32'(occ > 0));
            chk("op_count", 32'(op_count), 32'(m_cnt[15:0]));
            if (held_vld) begin
                chk("hold_sum", 32'(res_sum), 32'(held_sum));
                chk("hold_id", 32'(res_id), 32'(held_id));
            end
            held_vld = res_valid && !res_ready;
            held_sum = res_sum;
            held_id  = res_id;
            if (res_valid && res_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    it = q.pop_front();
                    chk("res_id", 32'(res_id), 32'(it.id));
                    chk("res_sum", 32'(res_sum), 32'(it.sum));
                    last_sum = res_sum;
                    last_id  = int'(res_id);
                    del_ids.push_back(int'(res_id));
                    m_cnt++;
                end
            end
            // Pipeline holds two items; it only refuses work when both are held and output stalled.
            g       = exp_grant(req_valid, m_ptr);
            can     = !(occ >= 2 && !res_ready);
            exp_rdy = (g >= 0 && can) ? N'(1 << g) : '0;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            acc_flag = '0;
            if (g >= 0 && can) begin
                it.id  = g;
                it.sum = 20'(req_x[g*19 +: 19]) + 20'(req_y[g*19 +: 19]);
                it.c   = ncyc;
                q.push_back(it);
                acc_flag[g] = 1'b1;
                m_ptr = next_ptr(g, m_ptr);
                tot_acc++;
                win_acc++;
            end
        end
    end

    // ---------------- driver ----------------
    logic [N-1:0] vld = '0;
    logic [18:0]  dx[N];
    logic [18:0]  dy[N];
    logic [N-1:0] en = '0;
    int           pct = 0;
    int           rdy_pct = 100;

    function automatic logic [18:0] rnd_op();
        int r;
        r = $urandom_range(3);
        if (r == 0) return 19'h7FFFF;
        if (r == 1) return 19'h00000;
        return 19'($urandom());
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_x[i*19 +: 19] = dx[i];
            req_y[i*19 +: 19] = dy[i];
        end
        req_valid = vld;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            if (acc_flag[i]) begin
                vld[i]      = 1'b0;
                acc_flag[i] = 1'b0;
            end
            if (!vld[i] && en[i] && ($urandom_range(99) < pct)) begin
                vld[i] = 1'b1;
                dx[i]  = rnd_op();
                dy[i]  = rnd_op();
            end
        end
        res_ready = ($urandom_range(99) < rdy_pct);
        pack();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic offer(input int i, input logic [18:0] x, input logic [18:0] y);
        vld[i] = 1'b1;
        dx[i]  = x;
        dy[i]  = y;
        pack();
    endtask

    task automatic wait_idle(input int budget);
        logic idle;
        idle = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (!busy && !res_valid && vld == '0 && q.size() == 0) begin
                idle = 1'b1;
                break;
            end
            step();
        end
        chk("drain_idle", 32'(idle), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            dx[i] = '0;
            dy[i] = '0;
        end
        rst       = 1'b1;
        res_ready = 1'b1;
        pack();
        do_reset();

        // Single request from requester 2.
        offer(2, 19'h7FFFF, 19'h00001);
        wait_idle(20);
        chk("t1_sum", 32'(last_sum), 32'h80000);
        chk("t1_id", 32'(last_id), 32'd2);
        chk("t1_count", 32'(op_count), 32'd1);

        // Carry out from requester 0.
        offer(0, 19'h7FFFF, 19'h7FFFF);
        wait_idle(20);
        chk("t2_sum", 32'(last_sum), 32'hFFFFE);
        chk("t2_id", 32'(last_id), 32'd0);

        // All requesters continuously valid from a fresh reset: strict rotation, full throughput.
        do_reset();
        del_ids.delete();
        en = '1; pct = 100; rdy_pct = 100;
        apply();
        repeat (12) step();
        chk("t3_thru", 32'(del_ids.size()), 32'd10);
        for (int k = 0; k < 8 && k < del_ids.size(); k++) begin
            chk("t3_rot", 32'(del_ids[k]), 32'(k % N));
        end
        en = '0;
        wait_idle(20);

        // Output stall for 5 cycles: exactly two accepts, then every ready low.
        win_acc = 0;
        en = '1; pct = 100; rdy_pct = 0;
        apply();
        repeat (5) step();
        chk("t4_accepts", 32'(win_acc), 32'd2);
        chk("t4_ready_low", 32'(req_ready), 32'd0);
        en = '0; rdy_pct = 100;
        apply();
        wait_idle(20);
        chk("t4_count", 32'(op_count), 32'(tot_acc[15:0]));

        // Reset while both stages are full.
        en = '1; pct = 100; rdy_pct = 0;
        apply();
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rdy_pct = 100;
        apply();
        @(negedge clk);
        #1;
        chk("t5_res_valid", 32'(res_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_count", 32'(op_count), 32'd0);
`ifndef ADD_ARB_PRIO0_EN
        chk("t5_first_grant", 32'(req_ready), 32'd1);
`endif
        en = '0;
        step();
        wait_idle(20);

`ifdef ADD_ARB_PRIO0_EN
        // Requesters 0 and 3 both busy: only 0 is served until it stops.
        del_ids.delete();
        en = 4'b1001; pct = 100; rdy_pct = 100;
        apply();
        repeat (8) step();
        for (int k = 0; k < del_ids.size(); k++) begin
            chk("prio_only0", 32'(del_ids[k]), 32'd0);
        end
        en = '0;
        wait_idle(20);
`endif

        // Random traffic with random output stalls.
        en = '1; pct = 40; rdy_pct = 70;
        apply();
        repeat (400) step();
        en = '0; rdy_pct = 100;
        apply();
        wait_idle(40);
        chk("final_count", 32'(op_count), 32'(tot_acc[15:0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end

endmodule
